systolic_sequencer: RTL
=======================

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 Parameter ARRAY_SIZE, default 8, SHALL set PE rows/cols and the width of the start masks.
REQ-002 Parameter DATA_W, default 16, SHALL set the operand width; fifo_start_alu width is 2*DATA_W, with ARRAY_SIZE <= DATA_W.
REQ-003 Parameter ADDR_W, default 7, SHALL set the SRAM address width.
REQ-004 Parameter TILE_W, default 4, SHALL set the tile-count width.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-006 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 tpu_start  in  1  SHALL be the job start request.
REQ-008 num_tiles  in  TILE_W  SHALL give the K-tiles to accumulate; sampled with tpu_start.
REQ-009 stall  in  1  SHALL be the freeze request, used only under SEQ_STALL_EN.
REQ-010 sram_rd_en  out  1  SHALL be the operand SRAM read strobe.
REQ-011 addr_serial_num  out  ADDR_W  SHALL be the operand SRAM read address.
REQ-012 fifo_start_alu  out  2*DATA_W  SHALL carry {data_start, weight_start}, each ARRAY_SIZE bits zero-extended to DATA_W.
REQ-013 alu_start  out  1  SHALL be the array shift/MAC enable.
REQ-014 acc_clear  out  1  SHALL be the PE accumulator clear pulse.
REQ-015 cycle_num  out  9  SHALL be the in-tile compute cycle.
REQ-016 sram_write_enable  out  1  SHALL be the result write strobe.
REQ-017 matrix_index  out  6  SHALL be the result row index.
REQ-018 tile_index  out  TILE_W  SHALL be the current tile.
REQ-019 busy  out  1  SHALL be high in any state other than IDLE.
REQ-020 tpu_done  out  1  SHALL be the one-cycle completion pulse.

Function
REQ-021 FSM states: IDLE, COMPUTE, WRITE, DONE.
REQ-022 IDLE + tpu_start=1 -> COMPUTE next cycle; latch T = num_tiles, with 0 treated as 1; tile_index=0, cycle_num=0.
REQ-023 tpu_start SHALL be ignored while busy=1.
REQ-024 COMPUTE per tile SHALL last L = 3*ARRAY_SIZE-2 cycles, with cycle_num stepping 0..L-1, and alu_start=1 throughout.
REQ-025 For cycle_num c < ARRAY_SIZE: sram_rd_en=1 and addr_serial_num = (tile_index*ARRAY_SIZE + c) mod 2^ADDR_W; otherwise sram_rd_en=0 and the address is held.
REQ-026 Skew: for c < ARRAY_SIZE, data_start and weight_start SHALL shift left inserting 1 each cycle; for c >= ARRAY_SIZE they SHALL shift left inserting 0; both are cleared at each tile start.
REQ-027 acc_clear SHALL be 1 only at cycle_num=0 of tile 0.
REQ-028 At c = L-1: if tile_index < T-1, increment tile_index, set cycle_num=0 and stay in COMPUTE; otherwise go to WRITE.
REQ-029 WRITE SHALL last ARRAY_SIZE cycles, with sram_write_enable=1 and matrix_index 0..ARRAY_SIZE-1; alu_start=0.
REQ-030 DONE SHALL last one cycle with tpu_done=1, then return to IDLE.
REQ-031 tpu_start=1 in the DONE cycle SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately force IDLE and drive every output and counter to 0, including during COMPUTE or WRITE.
REQ-033 After rst deasserts, the block SHALL wait for a new tpu_start and SHALL NOT resume the aborted job.

Configuration
REQ-034 The macro SEQ_STALL_EN SHALL select the stall feature.
REQ-035 With SEQ_STALL_EN defined: stall=1 in COMPUTE or WRITE SHALL hold state, counters, masks and address; force sram_rd_en, alu_start, acc_clear and sram_write_enable to 0; and resume exactly where it stopped.
REQ-036 Without SEQ_STALL_EN, stall SHALL be ignored.

Verification (ARRAY_SIZE=8; tpu_start pulsed at cycle 0)
REQ-037 num_tiles=1: COMPUTE cycles 1-22; addresses 0-7 on cycles 1-8; acc_clear at cycle 1; writes with matrix_index 0-7 on cycles 23-30; tpu_done at cycle 31.
REQ-038 num_tiles=2: second tile reads addresses 8-15 on cycles 23-30; acc_clear only at cycle 1; writes on cycles 45-52; tpu_done at cycle 53. num_tiles=0 SHALL behave as 1.
REQ-039 data_start SHALL read 0x01, 0x03, ... 0xFF over cycle_num 0-7, then 0xFE, ... 0x00 from cycle_num 8 onward.
REQ-040 tpu_start at cycle 10 and in the DONE cycle SHALL have no effect; timing SHALL match REQ-037.
REQ-041 rst=0 at cycle 12: all outputs are 0 the same cycle; after release, no activity until the next tpu_start.
REQ-042 SEQ_STALL_EN, stall on cycles 5-7: sram_rd_en=0 on those cycles, addresses 4-7 resume on cycles 8-11, tpu_done moves to cycle 34; without the macro, timing SHALL match REQ-037.

Source files
------------

// File: rtl/systolic_sequencer.sv
// Control sequencer for an ARRAY_SIZE x ARRAY_SIZE systolic array: operand reads, skewed start masks, tiling and result write-back.
// Optional stall/freeze support is compiled in with the SEQ_STALL_EN macro.
module systolic_sequencer #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 7,
    parameter int TILE_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tpu_start,
    input  logic [TILE_W-1:0]   num_tiles,
    input  logic                stall,
    output logic                sram_rd_en,
    output logic [ADDR_W-1:0]   addr_serial_num,
    output logic [2*DATA_W-1:0] fifo_start_alu,
    output logic                alu_start,
    output logic                acc_clear,
    output logic [8:0]          cycle_num,
    output logic                sram_write_enable,
    output logic [5:0]          matrix_index,
    output logic [TILE_W-1:0]   tile_index,
    output logic                busy,
    output logic                tpu_done
);

    localparam int TILE_LEN = 3 * ARRAY_SIZE - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [8:0]              cycle_r, cycle_s;
    logic [TILE_W-1:0]       tile_r, tile_s;
    logic [TILE_W-1:0]       tlast_r, tlast_s;
    logic [ADDR_W-1:0]       addr_r, addr_s;
    logic [ARRAY_SIZE-1:0]   dmask_r, dmask_s;
    logic [ARRAY_SIZE-1:0]   wmask_r, wmask_s;
    logic [5:0]              mindex_r, mindex_s;
    logic [8:0]              cycle_inc_s;
    logic                    hold_s;

    // Operand address of row c in tile t, wrapping at the SRAM depth.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [TILE_W-1:0] t, input logic [8:0] c);
        logic [31:0] full;
        full = 32'(t) * 32'(ARRAY_SIZE) + 32'(c);
        return full[ADDR_W-1:0];
    endfunction

`ifdef SEQ_STALL_EN
    assign hold_s = stall & ((state_r == S_COMPUTE) | (state_r == S_WRITE));
`else
    logic stall_unused_s;
    assign stall_unused_s = stall;
    assign hold_s = 1'b0;
`endif

    assign cycle_inc_s = cycle_r + 9'd1;

    // Next-state and next-counter computation; a stalled cycle keeps everything as is.
    always_comb begin
        state_s  = state_r;
        cycle_s  = cycle_r;
        tile_s   = tile_r;
        tlast_s  = tlast_r;
        addr_s   = addr_r;
        dmask_s  = dmask_r;
        wmask_s  = wmask_r;
        mindex_s = mindex_r;
        if (!hold_s) begin
            case (state_r)
                S_IDLE: begin
                    if (tpu_start) begin
                        state_s  = S_COMPUTE;
                        cycle_s  = 9'd0;
                        tile_s   = {TILE_W{1'b0}};
                        tlast_s  = (num_tiles == {TILE_W{1'b0}}) ? {TILE_W{1'b0}} : num_tiles - TILE_W'(1);
                        addr_s   = {ADDR_W{1'b0}};
                        dmask_s  = ARRAY_SIZE'(1);
                        wmask_s  = ARRAY_SIZE'(1);
                        mindex_s = 6'd0;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_COMPUTE: begin
                    if (cycle_r == 9'(TILE_LEN - 1)) begin
                        if (tile_r < tlast_r) begin
                            tile_s  = tile_r + TILE_W'(1);
                            cycle_s = 9'd0;
                            addr_s  = tile_addr(tile_r + TILE_W'(1), 9'd0);
                            dmask_s = ARRAY_SIZE'(1);
                            wmask_s = ARRAY_SIZE'(1);
                        end else begin
                            state_s  = S_WRITE;
                            cycle_s  = 9'd0;
                            dmask_s  = {ARRAY_SIZE{1'b0}};
                            wmask_s  = {ARRAY_SIZE{1'b0}};
                            mindex_s = 6'd0;
                        end
                    end else if (cycle_inc_s < 9'(ARRAY_SIZE)) begin
                        cycle_s = cycle_inc_s;
                        addr_s  = tile_addr(tile_r, cycle_inc_s);
                        dmask_s = {dmask_r[ARRAY_SIZE-2:0], 1'b1};
                        wmask_s = {wmask_r[ARRAY_SIZE-2:0], 1'b1};
                    end else begin
                        cycle_s = cycle_inc_s;
                        dmask_s = {dmask_r[ARRAY_SIZE-2:0], 1'b0};
                        wmask_s = {wmask_r[ARRAY_SIZE-2:0], 1'b0};
                    end
                end
                S_WRITE: begin
                    if (mindex_r == 6'(ARRAY_SIZE - 1)) begin
                        state_s = S_DONE;
                    end else begin
                        mindex_s = mindex_r + 6'd1;
                    end
                end
                S_DONE: begin
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Sequencer state, counters, masks and address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            cycle_r  <= 9'd0;
            tile_r   <= {TILE_W{1'b0}};
            tlast_r  <= {TILE_W{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            dmask_r  <= {ARRAY_SIZE{1'b0}};
            wmask_r  <= {ARRAY_SIZE{1'b0}};
            mindex_r <= 6'd0;
        end else begin
            state_r  <= state_s;
            cycle_r  <= cycle_s;
            tile_r   <= tile_s;
            tlast_r  <= tlast_s;
            addr_r   <= addr_s;
            dmask_r  <= dmask_s;
            wmask_r  <= wmask_s;
            mindex_r <= mindex_s;
        end
    end

    // Strobes are decoded from state so that a stall silences them in the same cycle.
    assign sram_rd_en        = (state_r == S_COMPUTE) & (cycle_r < 9'(ARRAY_SIZE)) & ~hold_s;
    assign alu_start         = (state_r == S_COMPUTE) & ~hold_s;
    assign acc_clear         = (state_r == S_COMPUTE) & (cycle_r == 9'd0) & (tile_r == {TILE_W{1'b0}}) & ~hold_s;
    assign sram_write_enable = (state_r == S_WRITE) & ~hold_s;
    assign busy              = (state_r != S_IDLE);
    assign tpu_done          = (state_r == S_DONE);
    assign addr_serial_num   = addr_r;
    assign fifo_start_alu    = {DATA_W'(dmask_r), DATA_W'(wmask_r)};
    assign cycle_num         = cycle_r;
    assign matrix_index      = mindex_r;
    assign tile_index        = tile_r;

endmodule
